// File: rtl/bus_arbiter_pkg.sv
// Shared types and default tuning values for the two-master data-bus arbiter.
package bus_arbiter_pkg;

  // Owner of the bus in the previous cycle; also used to name this cycle's grantee.
  typedef enum logic [1:0] {
    OWN_IDLE = 2'd0,
    OWN_0    = 2'd1,
    OWN_1    = 2'd2
  } owner_e;

  localparam int unsigned DEF_STARVE_LIMIT = 4;
  localparam int unsigned DEF_MAX_BURST    = 8;
  localparam int unsigned DEF_CNT_W        = 4;

endpackage

// File: rtl/bus_arbiter_sat_counter.sv
// Small saturating counter with clear and load-one controls (clear has priority).
module arb_sat_counter #(
  parameter int unsigned CNT_W = 4,
  parameter int unsigned MAX   = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc_i,
  input  logic             clr_i,
  input  logic             load1_i,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] MaxVal = CNT_W'(MAX);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: always_comb assigns a default first so no path leaves cnt_d unassigned (no latch).
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                         cnt_d = '0;
    else if (load1_i)                  cnt_d = CNT_W'(1);
    else if (inc_i && cnt_q != MaxVal) cnt_d = cnt_q + CNT_W'(1);
  end

  // NOTE: state registers use non-blocking assignments and a synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/bus_arbiter.sv
// Two-master data-bus arbiter: CPU (m0) by default, DMA (m1) via locked bursts
// or a forced grant once it has waited STARVE_LIMIT cycles. Bus is zero-latency.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT,
  parameter int unsigned MAX_BURST    = DEF_MAX_BURST,
  parameter int unsigned CNT_W        = DEF_CNT_W
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_byteen,
  output logic        m0_gnt,
  output logic [31:0] m0_rdata,
  output logic        m0_stall,
  input  logic        m1_req,
  input  logic        m1_lock,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_byteen,
  output logic        m1_gnt,
  output logic [31:0] m1_rdata,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_byteen,
  input  logic [31:0] bus_rdata
);

  localparam logic [CNT_W-1:0] MaxBurst    = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] StarveLimit = CNT_W'(STARVE_LIMIT);

  owner_e           owner_q, owner_d, grant;
  logic [CNT_W-1:0] burst_cnt, wait_cnt;
  logic             burst_inc, burst_load1, wait_inc;

  // Grant is forced to none during reset so no partial access reaches the bus.
  always_comb begin
    grant = OWN_IDLE;
    if (!reset_n)                                                     grant = OWN_IDLE;
    else if (owner_q == OWN_1 && m1_req && m1_lock && burst_cnt < MaxBurst) grant = OWN_1;
    else if (m1_req && wait_cnt >= StarveLimit)                       grant = OWN_1;
    else if (m0_req)                                                  grant = OWN_0;
    else if (m1_req)                                                  grant = OWN_1;
  end

  assign m0_gnt   = (grant == OWN_0);
  assign m1_gnt   = (grant == OWN_1);
  assign m0_stall = reset_n & m0_req & ~m0_gnt;
  assign m0_rdata = m0_gnt ? bus_rdata : '0;
  assign m1_rdata = m1_gnt ? bus_rdata : '0;

  always_comb begin
    bus_addr   = '0;
    bus_wdata  = '0;
    bus_byteen = '0;
    unique case (grant)
      OWN_0: begin
        bus_addr   = m0_addr;
        bus_wdata  = m0_wdata;
        bus_byteen = m0_byteen;
      end
      OWN_1: begin
        bus_addr   = m1_addr;
        bus_wdata  = m1_wdata;
        bus_byteen = m1_byteen;
      end
      default: ;
    endcase
  end

  assign owner_d = grant;

  always_ff @(posedge clk) begin
    if (!reset_n) owner_q <= OWN_IDLE;
    else          owner_q <= owner_d;
  end

  // A full burst followed by another m1 grant starts a fresh burst at 1.
  assign burst_inc   = m1_gnt && owner_q == OWN_1 && burst_cnt < MaxBurst;
  assign burst_load1 = m1_gnt && !burst_inc;
  assign wait_inc    = m1_req && !m1_gnt;

  arb_sat_counter #(.CNT_W(CNT_W), .MAX(MAX_BURST)) u_burst_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc_i   (burst_inc),
    .clr_i   (!m1_gnt),
    .load1_i (burst_load1),
    .cnt_o   (burst_cnt)
  );

  arb_sat_counter #(.CNT_W(CNT_W), .MAX(STARVE_LIMIT)) u_wait_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc_i   (wait_inc),
    .clr_i   (!wait_inc),
    .load1_i (1'b0),
    .cnt_o   (wait_cnt)
  );

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios then randomized traffic,
// every cycle compared against a rule-level reference model.
module tb_bus_arbiter;

  localparam int STARVE = 4;
  localparam int MAXB   = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        m0_req, m1_req, m1_lock;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, bus_rdata;
  logic [3:0]  m0_byteen, m1_byteen;
  logic        m0_gnt, m1_gnt, m0_stall;
  logic [31:0] m0_rdata, m1_rdata, bus_addr, bus_wdata;
  logic [3:0]  bus_byteen;

  always #5 clk = ~clk;

  bus_arbiter #(.STARVE_LIMIT(STARVE), .MAX_BURST(MAXB), .CNT_W(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .m0_req     (m0_req),
    .m0_addr    (m0_addr),
    .m0_wdata   (m0_wdata),
    .m0_byteen  (m0_byteen),
    .m0_gnt     (m0_gnt),
    .m0_rdata   (m0_rdata),
    .m0_stall   (m0_stall),
    .m1_req     (m1_req),
    .m1_lock    (m1_lock),
    .m1_addr    (m1_addr),
    .m1_wdata   (m1_wdata),
    .m1_byteen  (m1_byteen),
    .m1_gnt     (m1_gnt),
    .m1_rdata   (m1_rdata),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_byteen (bus_byteen),
    .bus_rdata  (bus_rdata)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", tag, cyc, obs, exp);
    end
  endtask

  // Reference model: who held the bus last cycle (-1 none), length of the current
  // uninterrupted m1 run, and how long m1 has been waiting.
  int last_g  = -1;
  int run_len = 0;
  int waited  = 0;

  // Evaluate one cycle: inputs are already driven, sample mid-cycle, then advance.
  task automatic step();
    int          g;
    logic [31:0] ea, ew;
    logic [3:0]  eb;
    bus_rdata = $urandom();
    #4;
    if (!reset_n)                                                    g = -1;
    else if (last_g == 1 && m1_req && m1_lock && run_len < MAXB)     g = 1;
    else if (m1_req && waited >= STARVE)                             g = 1;
    else if (m0_req)                                                 g = 0;
    else if (m1_req)                                                 g = 1;
    else                                                             g = -1;
    ea = (g == 0) ? m0_addr   : (g == 1) ? m1_addr   : 32'h0;
    ew = (g == 0) ? m0_wdata  : (g == 1) ? m1_wdata  : 32'h0;
    eb = (g == 0) ? m0_byteen : (g == 1) ? m1_byteen : 4'h0;
    check("m0_gnt",     32'(m0_gnt),     32'(g == 0));
    check("m1_gnt",     32'(m1_gnt),     32'(g == 1));
    check("m0_stall",   32'(m0_stall),   32'(reset_n && m0_req && g != 0));
    check("bus_addr",   bus_addr,        ea);
    check("bus_wdata",  bus_wdata,       ew);
    check("bus_byteen", 32'(bus_byteen), 32'(eb));
    check("m0_rdata",   m0_rdata,        (g == 0) ? bus_rdata : 32'h0);
    check("m1_rdata",   m1_rdata,        (g == 1) ? bus_rdata : 32'h0);
    if (!reset_n) begin
      run_len = 0;
      waited  = 0;
    end else begin
      if (g == 1) run_len = (last_g == 1 && run_len < MAXB) ? run_len + 1 : 1;
      else        run_len = 0;
      waited = (m1_req && g != 1) ? waited + 1 : 0;
    end
    last_g = g;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_req = 1'b0; m0_addr = '0; m0_wdata = '0; m0_byteen = '0;
    m1_req = 1'b0; m1_lock = 1'b0; m1_addr = '0; m1_wdata = '0; m1_byteen = '0;
  endtask

  int beats;
  bit m0_pend, m1_pend;

  initial begin
    reset_n = 1'b0;
    bus_rdata = '0;
    idle_inputs();
    @(posedge clk);
    #1;

    // Reset with both masters requesting: nothing granted, then m0 first.
    m0_req = 1'b1; m0_byteen = 4'hf; m0_addr = 32'h100;
    m1_req = 1'b1; m1_addr = 32'h200;
    step(); step();
    reset_n = 1'b1;
    step();

    // m0-only store.
    idle_inputs();
    step();
    m0_req = 1'b1; m0_addr = 32'h7f04; m0_byteen = 4'hf; m0_wdata = 32'h10;
    step();

    // Both request without lock: m0 four times, forced m1, then m0 again.
    m1_req = 1'b1; m1_addr = 32'h3000; m1_byteen = 4'h0;
    repeat (8) step();

    // Locked m1 read burst of 12 with m0 requesting.
    idle_inputs();
    step();
    m0_req = 1'b1; m0_addr = 32'h44; m0_byteen = 4'h0;
    m1_req = 1'b1; m1_lock = 1'b1; m1_addr = 32'h8000;
    beats = 0;
    for (int i = 0; i < 60 && beats < 12; i++) begin
      step();
      if (last_g == 1) begin
        beats++;
        m1_addr = m1_addr + 32'd4;
      end
    end
    check("burst12_done", 32'(beats), 32'd12);

    // Lock drops after beat 3 of a burst.
    idle_inputs();
    step();
    m1_req = 1'b1; m1_lock = 1'b1; m1_addr = 32'h9000;
    beats = 0;
    for (int i = 0; i < 20 && beats < 3; i++) begin
      step();
      if (last_g == 1) beats++;
      if (beats == 1) begin
        m0_req = 1'b1; m0_addr = 32'h48;
      end
    end
    check("lockdrop_beats", 32'(beats), 32'd3);
    m1_lock = 1'b0;
    repeat (3) step();

    // Reset pulsed mid-burst at beat 5.
    idle_inputs();
    step();
    m1_req = 1'b1; m1_lock = 1'b1; m1_byteen = 4'h3; m1_wdata = 32'hdead_beef;
    beats = 0;
    for (int i = 0; i < 20 && beats < 4; i++) begin
      step();
      if (last_g == 1) beats++;
    end
    check("rst_burst_beats", 32'(beats), 32'd4);
    m0_req = 1'b1; m0_addr = 32'h4c; m0_byteen = 4'h1;
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    step();

    // Randomized traffic: each master holds its request until granted.
    idle_inputs();
    m0_pend = 1'b0;
    m1_pend = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (!m0_pend && $urandom_range(1, 0) == 1) begin
        m0_pend   = 1'b1;
        m0_addr   = $urandom() & 32'hffff_fffc;
        m0_wdata  = $urandom();
        m0_byteen = 4'($urandom());
      end
      if (!m1_pend && $urandom_range(2, 0) != 0) begin
        m1_pend   = 1'b1;
        m1_addr   = $urandom() & 32'hffff_fffc;
        m1_wdata  = $urandom();
        m1_byteen = 4'($urandom());
      end
      m0_req  = m0_pend;
      m1_req  = m1_pend;
      m1_lock = m1_pend && ($urandom_range(3, 0) != 0);
      reset_n = ($urandom_range(63, 0) != 0);
      step();
      if (last_g == 0) m0_pend = 1'b0;
      if (last_g == 1) m1_pend = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
